data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Data-memory and memory-mapped I/O controller directly downstream of the single-cycle CPU core.
- Consumes the core's ram_addr, data_mem_in, mem_rd and mem_wr outputs, and returns data_mem_out.
- Word-addressed RAM occupies the low address space. The top 16 words are an MMIO window:
  - GPIO out and GPIO in (synchronised)
  - free-running cycle counter
  - sticky error register
- Reads are combinational so the core can write memory_in into its register file on the same edge. Writes commit on the rising edge.

Parameters:
- ADDR_W, 12, word-address width; must match the core's ram_addr.
- DATA_W, 32, data word width.
- RAM_WORDS, 4080, RAM depth; words 0 to RAM_WORDS-1, must be <= 2^ADDR_W - 16.
- GPIO_W, 8, width of GPIO in/out ports.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- mem_rd  input  1  read strobe from core, sampled per cycle.
- mem_wr  input  1  write strobe from core.
- ram_addr  input  ADDR_W  word address.
- data_mem_in  input  DATA_W  write data.
- data_mem_out  output  DATA_W  read data, combinational from address.
- gpio_in  input  GPIO_W  asynchronous external inputs.
- gpio_out  output  GPIO_W  registered output port.
- bus_err  output  1  sticky access-error flag.

Behaviour:
Address map:
- 0x000 to RAM_WORDS-1: RAM.
- 0xFF0: GPIO_OUT, R/W; low GPIO_W bits used, upper bits read 0.
- 0xFF1: GPIO_IN, RO; the 2-flop synchronised gpio_in, zero-extended.
- 0xFF2: CYCLE, RO counter; writing any value clears it to 0.
- 0xFF3: ERR, bit0 = bus_err; writing 1 to bit0 clears it.
- Any other address (RAM_WORDS to 0xFEF, and 0xFF4 to 0xFFF) is unmapped.

Reads:
- When mem_rd=1, data_mem_out = selected location, combinational, zero cycles.
- When mem_rd=0, data_mem_out = 0.
- RAM read returns the contents from before any write committing at the same edge (read-before-write).

Writes:
- When mem_wr=1, the target updates at the rising edge.
- RAM contents are not reset and start undefined.
- RO locations ignore writes, except the CYCLE clear.

Simultaneous mem_rd and mem_wr:
- Legal.
- The read returns the old value and the write commits at the edge.

Unmapped access:
- A read with mem_rd=1 returns 0 and sets bus_err at the next edge.
- A write is dropped and sets bus_err.
- A write of 1 to ERR bit0 in the same cycle as an error-causing event cannot occur, since only one address is presented per cycle.

CYCLE counter:
- Increments by 1 every clk edge when not reset.
- Wraps from 0xFFFFFFFF to 0.
- A write to CYCLE loads 0 at that edge; the increment is suppressed that cycle.
- A read returns the pre-edge value.

GPIO in:
- Synchroniser gives 2 cycles of latency from a gpio_in change to its visibility at 0xFF1.

Reset (reset=0, asynchronous):
- gpio_out=0, CYCLE=0, bus_err=0, synchroniser flops=0.
- data_mem_out follows the combinational rules; it reads 0 when mem_rd=0.
- Reset asserted mid-write aborts that write for register targets; the RAM write may or may not commit.
- Release: the first increment occurs on the first rising edge after reset rises.

Strobe rules:
- X on mem_rd or mem_wr while out of reset is a bench assertion failure.
- Strobes may change every cycle; there is no handshake or stall.
- Every access completes in one cycle.

Test Plan:
- Reset, then write 0xDEADBEEF to RAM 0x005 and read back next cycle -> data_mem_out=0xDEADBEEF. Read 0x006 with mem_rd=0 -> data_mem_out=0.
- Same-cycle rd+wr to 0x010 holding 0x11111111, writing 0x22222222 -> data_mem_out=0x11111111 that cycle, 0x22222222 on the next read.
- Write 0x1A5 to 0xFF0 -> gpio_out=0xA5 after the edge; reading 0xFF0 -> 0x000000A5.
- Drive gpio_in=0x3C -> reading 0xFF1 returns 0 for 2 cycles, then 0x0000003C.
- Run 10 cycles after reset, then read 0xFF2 -> 10. Write 0xFF2 -> the next read returns 1.
- Read 0xFF8, then write 0xFFF -> data_mem_out=0 and bus_err=1 after the first edge. Write 0x1 to 0xFF3 -> bus_err=0.
- Assert reset mid-count -> CYCLE, gpio_out and bus_err all 0 immediately, without a clock edge.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Data memory and memory-mapped I/O controller sitting behind the single-cycle core.
// Word-addressed RAM fills the low address space; the top 16 words hold GPIO,
// a free-running cycle counter and a sticky bus-error flag. Reads are fully
// combinational so the core can retire a load in the same cycle it issues it.
module data_mem_ctrl #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int RAM_WORDS = 4080,
  parameter int GPIO_W    = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] data_mem_in,
  output logic [DATA_W-1:0] data_mem_out,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic              bus_err
);

  localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [ADDR_W:0] RAM_LIMIT = (ADDR_W+1)'(RAM_WORDS);

  // MMIO register offsets within the top 16-word window
  localparam logic [3:0] OFS_GPIO_OUT = 4'h0;
  localparam logic [3:0] OFS_GPIO_IN  = 4'h1;
  localparam logic [3:0] OFS_CYCLE    = 4'h2;
  localparam logic [3:0] OFS_ERR      = 4'h3;

  // RAM storage has no reset; contents start undefined
  logic [DATA_W-1:0] ramQ [RAM_WORDS];
  logic [RAM_AW-1:0] ramIdx;

  logic [GPIO_W-1:0] gpioOutQ, gpioOutD;
  logic [GPIO_W-1:0] syncMetaQ, syncOutQ;
  logic [DATA_W-1:0] cycleQ, cycleD;
  logic              errQ, errD;

  logic ramSel, mmioSel, gpioOutSel, gpioInSel, cycleSel, errSel, unmapped;
  logic [DATA_W-1:0] rdData;

  assign ramIdx     = ram_addr[RAM_AW-1:0];
  assign ramSel     = ({1'b0, ram_addr} < RAM_LIMIT);
  assign mmioSel    = &ram_addr[ADDR_W-1:4];
  assign gpioOutSel = mmioSel && (ram_addr[3:0] == OFS_GPIO_OUT);
  assign gpioInSel  = mmioSel && (ram_addr[3:0] == OFS_GPIO_IN);
  assign cycleSel   = mmioSel && (ram_addr[3:0] == OFS_CYCLE);
  assign errSel     = mmioSel && (ram_addr[3:0] == OFS_ERR);
  assign unmapped   = !(ramSel || gpioOutSel || gpioInSel || cycleSel || errSel);

  // Combinational read mux; reads of RAM see pre-edge contents (read-before-write)
  always_comb begin
    rdData = '0;
    if (mem_rd) begin
      if (ramSel) begin
        rdData = ramQ[ramIdx];
      end else if (gpioOutSel) begin
        rdData = DATA_W'(gpioOutQ);
      end else if (gpioInSel) begin
        rdData = DATA_W'(syncOutQ);
      end else if (cycleSel) begin
        rdData = cycleQ;
      end else if (errSel) begin
        rdData = DATA_W'(errQ);
      end
    end
  end

  assign data_mem_out = rdData;
  assign gpio_out     = gpioOutQ;
  assign bus_err      = errQ;

  // RAM write port, committed on the rising edge
  always_ff @(posedge clk) begin
    if (mem_wr && ramSel) begin
      ramQ[ramIdx] <= data_mem_in;
    end
  end

  // Next-state logic for the MMIO registers
  always_comb begin
    gpioOutD = gpioOutQ;
    cycleD   = cycleQ + 1'b1;
    errD     = errQ;
    if (mem_wr && gpioOutSel) begin
      gpioOutD = data_mem_in[GPIO_W-1:0];
    end
    if (mem_wr && cycleSel) begin
      cycleD = '0;
    end
    if ((mem_rd || mem_wr) && unmapped) begin
      errD = 1'b1;
    end else if (mem_wr && errSel && data_mem_in[0]) begin
      errD = 1'b0;
    end
  end

  // MMIO registers and the two-flop gpio_in synchroniser, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpioOutQ  <= '0;
      syncMetaQ <= '0;
      syncOutQ  <= '0;
      cycleQ    <= '0;
      errQ      <= 1'b0;
    end else begin
      gpioOutQ  <= gpioOutD;
      syncMetaQ <= gpio_in;
      syncOutQ  <= syncMetaQ;
      cycleQ    <= cycleD;
      errQ      <= errD;
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl: directed scenarios followed by random
// traffic, all compared against a behavioural model of the address map.
module tb_data_mem_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [11:0] ram_addr = '0;
  logic [31:0] data_mem_in = '0;
  logic [31:0] data_mem_out;
  logic [7:0]  gpio_in = '0;
  logic [7:0]  gpio_out;
  logic        bus_err;

  int assertCount = 0;
  int failCount = 0;

  // Behavioural model state
  logic [31:0] refMem [4096];
  bit          refValid [4096];
  logic [7:0]  refGpioOut;
  logic [7:0]  refGpioHist [2];
  logic [31:0] refCycle;
  logic        refErr;

  // Values observed in the most recent applyStimulus cycle, before its edge
  logic [31:0] lastRead;
  logic        lastErr;
  logic [7:0]  lastGpio;

  data_mem_ctrl #(
    .ADDR_W(12), .DATA_W(32), .RAM_WORDS(4080), .GPIO_W(8)
  ) dut (
    .clk(clk),
    .reset(reset),
    .mem_rd(mem_rd),
    .mem_wr(mem_wr),
    .ram_addr(ram_addr),
    .data_mem_in(data_mem_in),
    .data_mem_out(data_mem_out),
    .gpio_in(gpio_in),
    .gpio_out(gpio_out),
    .bus_err(bus_err)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  // Strobes must never be unknown while out of reset
  always @(posedge clk) begin
    if (reset && ($isunknown(mem_rd) || $isunknown(mem_wr))) begin
      failCount++;
      $display("[TB] FAIL strobe_x: mem_rd=%b mem_wr=%b, required known values", mem_rd, mem_wr);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    refGpioOut     = '0;
    refGpioHist[0] = '0;
    refGpioHist[1] = '0;
    refCycle       = '0;
    refErr         = 1'b0;
  endtask

  function automatic bit isMapped(input logic [11:0] a);
    return (a < 12'd4080) || (a >= 12'hFF0 && a <= 12'hFF3);
  endfunction

  // Expected read value; returns 0 when the answer depends on unwritten RAM
  function automatic bit modelRead(input logic rd, input logic [11:0] a, output logic [31:0] v);
    v = '0;
    if (!rd) return 1'b1;
    if (a < 12'd4080) begin
      v = refMem[a];
      return refValid[a];
    end
    case (a)
      12'hFF0: v = {24'h0, refGpioOut};
      12'hFF1: v = {24'h0, refGpioHist[1]};
      12'hFF2: v = refCycle;
      12'hFF3: v = {31'h0, refErr};
      default: v = '0;
    endcase
    return 1'b1;
  endfunction

  task automatic modelEdge(input logic rd, input logic wr, input logic [11:0] a,
                           input logic [31:0] d, input logic [7:0] g);
    if (wr && a < 12'd4080) begin
      refMem[a]   = d;
      refValid[a] = 1'b1;
    end
    if (wr && a == 12'hFF0) refGpioOut = d[7:0];
    if (wr && a == 12'hFF2) refCycle = '0;
    else refCycle = refCycle + 32'd1;
    if ((rd || wr) && !isMapped(a)) refErr = 1'b1;
    else if (wr && a == 12'hFF3 && d[0]) refErr = 1'b0;
    refGpioHist[1] = refGpioHist[0];
    refGpioHist[0] = g;
  endtask

  // One bus cycle: drive at negedge, check pre-edge outputs, advance model at posedge
  task automatic applyStimulus(input string tag, input logic rd, input logic wr,
                               input logic [11:0] a, input logic [31:0] d, input logic [7:0] g);
    logic [31:0] expData;
    bit          known;
    @(negedge clk);
    mem_rd      = rd;
    mem_wr      = wr;
    ram_addr    = a;
    data_mem_in = d;
    gpio_in     = g;
    #1;
    lastRead = data_mem_out;
    lastErr  = bus_err;
    lastGpio = gpio_out;
    known = modelRead(rd, a, expData);
    if (known) checkOutput({tag, "_data"}, data_mem_out, expData);
    checkOutput({tag, "_gpio_out"}, {24'h0, gpio_out}, {24'h0, refGpioOut});
    checkOutput({tag, "_bus_err"}, {31'h0, bus_err}, {31'h0, refErr});
    @(posedge clk);
    if (reset) modelEdge(rd, wr, a, d, g);
  endtask

  // Release reset away from the edge; the following edge is the first counted one
  task automatic releaseReset();
    @(negedge clk);
    reset  = 1'b1;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    @(posedge clk);
    modelEdge(1'b0, 1'b0, ram_addr, data_mem_in, gpio_in);
  endtask

  initial begin
    logic [11:0] a;
    logic [31:0] d;
    logic [7:0]  g;
    logic        rd, wr;
    int          sel;

    modelReset();

    // Held in reset: registers read as zero, nothing advances
    applyStimulus("rst_cycle", 1'b1, 1'b0, 12'hFF2, 32'h0, 8'h00);
    checkOutput("rst_cycle_const", lastRead, 32'h0);
    applyStimulus("rst_idle", 1'b0, 1'b0, 12'hFF0, 32'h0, 8'h00);
    checkOutput("rst_gpio_const", {24'h0, lastGpio}, 32'h0);
    checkOutput("rst_err_const", {31'h0, lastErr}, 32'h0);
    releaseReset();

    // Ten edges after release, then read CYCLE
    for (int i = 0; i < 9; i++) applyStimulus("count_idle", 1'b0, 1'b0, 12'h000, 32'h0, 8'h00);
    applyStimulus("cycle_read", 1'b1, 1'b0, 12'hFF2, 32'h0, 8'h00);
    checkOutput("cycle_ten", lastRead, 32'd10);
    // Clear CYCLE; one edge later it has counted to 1
    applyStimulus("cycle_clr", 1'b0, 1'b1, 12'hFF2, 32'h1234, 8'h00);
    applyStimulus("cycle_idle", 1'b0, 1'b0, 12'h000, 32'h0, 8'h00);
    applyStimulus("cycle_read2", 1'b1, 1'b0, 12'hFF2, 32'h0, 8'h00);
    checkOutput("cycle_after_clr", lastRead, 32'd1);

    // RAM write then read back; rd low forces zero
    applyStimulus("ram_wr5", 1'b0, 1'b1, 12'h005, 32'hDEADBEEF, 8'h00);
    applyStimulus("ram_rd5", 1'b1, 1'b0, 12'h005, 32'h0, 8'h00);
    checkOutput("ram_rd5_const", lastRead, 32'hDEADBEEF);
    applyStimulus("ram_nord6", 1'b0, 1'b0, 12'h006, 32'h0, 8'h00);
    checkOutput("ram_nord6_const", lastRead, 32'h0);

    // Same-cycle read and write returns the old word
    applyStimulus("ram_wr10", 1'b0, 1'b1, 12'h010, 32'h11111111, 8'h00);
    applyStimulus("ram_rw10", 1'b1, 1'b1, 12'h010, 32'h22222222, 8'h00);
    checkOutput("ram_rw10_old", lastRead, 32'h11111111);
    applyStimulus("ram_rd10", 1'b1, 1'b0, 12'h010, 32'h0, 8'h00);
    checkOutput("ram_rd10_new", lastRead, 32'h22222222);

    // GPIO out keeps only its low bits
    applyStimulus("gpo_wr", 1'b0, 1'b1, 12'hFF0, 32'h1A5, 8'h00);
    applyStimulus("gpo_rd", 1'b1, 1'b0, 12'hFF0, 32'h0, 8'h00);
    checkOutput("gpo_rd_const", lastRead, 32'h000000A5);
    checkOutput("gpo_pin_const", {24'h0, lastGpio}, 32'hA5);

    // GPIO in appears after two synchroniser edges
    applyStimulus("gpi_rd0", 1'b1, 1'b0, 12'hFF1, 32'h0, 8'h3C);
    checkOutput("gpi_lat0", lastRead, 32'h0);
    applyStimulus("gpi_rd1", 1'b1, 1'b0, 12'hFF1, 32'h0, 8'h3C);
    checkOutput("gpi_lat1", lastRead, 32'h0);
    applyStimulus("gpi_rd2", 1'b1, 1'b0, 12'hFF1, 32'h0, 8'h3C);
    checkOutput("gpi_lat2", lastRead, 32'h3C);

    // Unmapped read and write raise the sticky error; ERR write of 1 clears it
    applyStimulus("unm_rd", 1'b1, 1'b0, 12'hFF8, 32'h0, 8'h3C);
    checkOutput("unm_rd_zero", lastRead, 32'h0);
    applyStimulus("unm_wr", 1'b0, 1'b1, 12'hFFF, 32'hFFFFFFFF, 8'h3C);
    checkOutput("unm_err_set", {31'h0, lastErr}, 32'h1);
    applyStimulus("err_rd", 1'b1, 1'b0, 12'hFF3, 32'h0, 8'h3C);
    checkOutput("err_rd_const", lastRead, 32'h1);
    applyStimulus("err_clr", 1'b0, 1'b1, 12'hFF3, 32'h1, 8'h3C);
    applyStimulus("err_idle", 1'b0, 1'b0, 12'h000, 32'h0, 8'h3C);
    checkOutput("err_cleared", {31'h0, lastErr}, 32'h0);

    // Random traffic over RAM, MMIO and unmapped addresses
    for (int i = 0; i < 500; i++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 6)      a = 12'($urandom_range(0, 31));
      else if (sel < 8) a = 12'hFF0 + 12'($urandom_range(0, 3));
      else              a = 12'hFF4 + 12'($urandom_range(0, 11));
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 2) == 0);
      d  = $urandom;
      g  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : gpio_in;
      applyStimulus("rand", rd, wr, a, d, g);
    end

    // Make sure registers are non-zero, then reset asynchronously mid-cycle
    applyStimulus("pre_gpo", 1'b0, 1'b1, 12'hFF0, 32'h55, 8'h00);
    applyStimulus("pre_err", 1'b1, 1'b0, 12'hFFA, 32'h0, 8'h00);
    @(negedge clk);
    mem_rd   = 1'b1;
    mem_wr   = 1'b0;
    ram_addr = 12'hFF2;
    #2;
    checkOutput("pre_rst_err", {31'h0, bus_err}, 32'h1);
    checkOutput("pre_rst_gpio", {24'h0, gpio_out}, 32'h55);
    reset = 1'b0;
    #1;
    modelReset();
    checkOutput("async_cycle", data_mem_out, 32'h0);
    checkOutput("async_gpio", {24'h0, gpio_out}, 32'h0);
    checkOutput("async_err", {31'h0, bus_err}, 32'h0);
    @(posedge clk);
    applyStimulus("in_rst", 1'b1, 1'b0, 12'hFF2, 32'h0, 8'h00);
    releaseReset();

    // A short burst of random traffic after the second release
    for (int i = 0; i < 100; i++) begin
      a  = ($urandom_range(0, 1) == 0) ? 12'($urandom_range(0, 31)) : 12'hFF0 + 12'($urandom_range(0, 15));
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 3) == 0);
      applyStimulus("rand2", rd, wr, a, $urandom, 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
